// File: rtl/load_counter_pkg.sv
// Shared encodings for the load counter: boundary mode and count direction.
package load_counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and boundary detection for one enabled step.
module counter_next
   import load_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] max,
   input  logic             up,
   input  logic             mode,
   output logic [WIDTH-1:0] next,
   output logic             boundary
);

   always_comb begin
      next     = count;
      boundary = 1'b0;
      if (up == DIR_UP) begin
         // >= so a count stranded above a lowered max still hits the boundary
         if (count >= max) begin
            boundary = 1'b1;
            next     = (mode == MODE_SAT) ? max : '0;
         end else begin
            next = count + 1'b1;
         end
      end else begin
         if (count == '0) begin
            boundary = 1'b1;
            next     = (mode == MODE_SAT) ? '0 : max;
         end else begin
            next = count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/load_counter.sv
// Up/down counter with programmable limit, wrap/saturate modes, terminal-count
// pulse and sticky boundary flag; load has priority over counting.
module load_counter
   import load_counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] max_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] step_val;
   logic             step_bnd;
   logic [WIDTH-1:0] load_clamped;

   counter_next #(.WIDTH(WIDTH)) u_next (
      .count    (count_o),
      .max      (max_i),
      .up       (up_i),
      .mode     (mode_i),
      .next     (step_val),
      .boundary (step_bnd)
   );

   assign load_clamped = (load_val_i > max_i) ? max_i : load_val_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_o <= WIDTH'(RESET_VAL);
         tc_o    <= 1'b0;
         ovf_o   <= 1'b0;
      end else if (load_i) begin
         count_o <= load_clamped;
         tc_o    <= 1'b0;
         ovf_o   <= 1'b0;
      end else if (en_i) begin
         count_o <= step_val;
         tc_o    <= step_bnd;
         ovf_o   <= ovf_o | step_bnd;
      end else begin
         tc_o    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_load_counter.sv
// Directed table-driven bench for load_counter (WIDTH=4, RESET_VAL=3).
module tb_load_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_i;
   logic [3:0] load_val_i;
   logic       en_i;
   logic       up_i;
   logic       mode_i;
   logic [3:0] max_i;
   logic [3:0] count_o;
   logic       tc_o;
   logic       ovf_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       load;
      logic [3:0] lval;
      logic       en;
      logic       up;
      logic       mode;
      logic [3:0] max;
      logic [3:0] ec;
      logic       etc;
      logic       eovf;
   } vec_t;

   vec_t vt[$];

   load_counter #(.WIDTH(4), .RESET_VAL(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .en_i       (en_i),
      .up_i       (up_i),
      .mode_i     (mode_i),
      .max_i      (max_i),
      .count_o    (count_o),
      .tc_o       (tc_o),
      .ovf_o      (ovf_o)
   );

   always #5 clk = ~clk;

   task automatic add(input logic ld, input logic [3:0] lv, input logic en,
                      input logic up, input logic md, input logic [3:0] mx,
                      input logic [3:0] ec, input logic etc, input logic eovf);
      vec_t v;
      v.load = ld; v.lval = lv; v.en = en; v.up = up; v.mode = md; v.max = mx;
      v.ec = ec; v.etc = etc; v.eovf = eovf;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] ec,
                        input logic etc, input logic eovf);
      checks++;
      if (count_o !== ec || tc_o !== etc || ovf_o !== eovf) begin
         failures++;
         $display("FAIL %s: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                  name, count_o, tc_o, ovf_o, ec, etc, eovf);
      end
   endtask

   task automatic drive(input logic ld, input logic [3:0] lv, input logic en,
                        input logic up, input logic md, input logic [3:0] mx);
      load_i = ld; load_val_i = lv; en_i = en; up_i = up; mode_i = md; max_i = mx;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 4'd0, 0, 1, 0, 4'd9);
      #1;
      check("reset_initial", 4'd3, 1'b0, 1'b0);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", 4'd3, 1'b0, 1'b0);

      // ld lval en up mode max | count tc ovf
      add(1, 4'd0, 0, 1, 0, 4'd9,  4'd0, 0, 0);
      for (int i = 1; i <= 9; i++)
         add(0, 4'd0, 1, 1, 0, 4'd9, 4'(i), 0, 0);
      add(0, 4'd0, 1, 1, 0, 4'd9,  4'd0, 1, 1);
      add(0, 4'd0, 1, 1, 0, 4'd9,  4'd1, 0, 1);
      add(0, 4'd0, 0, 1, 0, 4'd9,  4'd1, 0, 1);
      // load wins over en and clamps to max
      add(1, 4'd12, 1, 1, 0, 4'd10, 4'd10, 0, 0);
      add(1, 4'd7,  0, 1, 0, 4'd10, 4'd7,  0, 0);
      // saturate down from 2
      add(1, 4'd2, 0, 0, 1, 4'd15, 4'd2, 0, 0);
      add(0, 4'd0, 1, 0, 1, 4'd15, 4'd1, 0, 0);
      add(0, 4'd0, 1, 0, 1, 4'd15, 4'd0, 0, 0);
      add(0, 4'd0, 1, 0, 1, 4'd15, 4'd0, 1, 1);
      add(0, 4'd0, 1, 0, 1, 4'd15, 4'd0, 1, 1);
      add(0, 4'd0, 0, 0, 1, 4'd15, 4'd0, 0, 1);
      // max lowered below count, then reverse direction
      add(1, 4'd8, 0, 1, 0, 4'd15, 4'd8, 0, 0);
      add(0, 4'd0, 1, 1, 0, 4'd5,  4'd0, 1, 1);
      add(0, 4'd0, 1, 0, 0, 4'd5,  4'd5, 1, 1);
      add(0, 4'd0, 1, 0, 0, 4'd5,  4'd4, 0, 1);
      // stranded above max, down step decrements normally
      add(1, 4'd8, 0, 1, 0, 4'd15, 4'd8, 0, 0);
      add(0, 4'd0, 1, 0, 0, 4'd5,  4'd7, 0, 0);
      // max = 0, both modes, toggling direction
      add(1, 4'd0, 0, 1, 0, 4'd0, 4'd0, 0, 0);
      add(0, 4'd0, 1, 1, 0, 4'd0, 4'd0, 1, 1);
      add(0, 4'd0, 1, 0, 0, 4'd0, 4'd0, 1, 1);
      add(0, 4'd0, 1, 1, 1, 4'd0, 4'd0, 1, 1);
      add(0, 4'd0, 1, 0, 1, 4'd0, 4'd0, 1, 1);
      add(0, 4'd0, 0, 0, 1, 4'd0, 4'd0, 0, 1);
      // full-range wrap and saturate at 15
      add(1, 4'd15, 0, 1, 1, 4'd15, 4'd15, 0, 0);
      add(0, 4'd0,  1, 1, 1, 4'd15, 4'd15, 1, 1);
      add(0, 4'd0,  1, 1, 0, 4'd15, 4'd0,  1, 1);
      add(0, 4'd0,  1, 1, 0, 4'd15, 4'd1,  0, 1);

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].load, vt[i].lval, vt[i].en, vt[i].up, vt[i].mode, vt[i].max);
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), vt[i].ec, vt[i].etc, vt[i].eovf);
      end

      // async reset mid-cycle discards a pending load and clears sticky state
      drive(1, 4'd9, 0, 1, 0, 4'd9);
      @(posedge clk); #1;
      drive(0, 4'd0, 1, 1, 0, 4'd9);
      @(posedge clk); #1;
      check("pre_reset_boundary", 4'd0, 1'b1, 1'b1);
      drive(1, 4'd2, 1, 1, 0, 4'd9);
      #2 reset = 1'b1;
      #1;
      check("async_reset_now", 4'd3, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("reset_held_edge", 4'd3, 1'b0, 1'b0);
      reset = 1'b0;
      // RESET_VAL above max: first up-step is a boundary
      drive(0, 4'd0, 1, 1, 0, 4'd2);
      @(posedge clk); #1;
      check("resetval_over_max", 4'd0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("after_reset_count", 4'd1, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
